router_output_allocator: RTL and testbench

Switch allocator for the NoC router. It shares each router output port among the router's input ports with per-output round-robin arbitration. It holds wormhole locks from head to tail flit, tracks downstream credits per output, and masks prohibited turns. It sits between the route-compute/input-buffer stage and the crossbar inside the router, in the `clk_noc` domain.

---
 rtl/router_output_allocator_pkg.sv | 25 ++
 rtl/router_output_allocator_rr_arbiter.sv | 43 ++++
 rtl/router_output_allocator.sv | 163 ++++++++++++++++
 tb/tb_router_output_allocator.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/router_output_allocator_pkg.sv
// Shared types and width helpers for the router switch allocator.
package router_alloc_pkg;

    // Per-output allocation state: free, or held by a packet in flight.
    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } alloc_state_e;

    // Crossbar select width; never narrower than one bit.
    function automatic int sel_width_f(input int num_inputs);
        return (num_inputs > 1) ? $clog2(num_inputs) : 1;
    endfunction

    // Route field width; never narrower than one bit.
    function automatic int port_width_f(input int num_outputs);
        return (num_outputs > 1) ? $clog2(num_outputs) : 1;
    endfunction

    // Credit counter must hold 0..depth inclusive.
    function automatic int credit_width_f(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/router_output_allocator_rr_arbiter.sv
// Round-robin arbiter: picks the first request at or after ptr (wrapping),
// and computes the pointer to store when the grant is actually taken.
module rr_arbiter
    import router_alloc_pkg::*;
#(
    parameter int N = 5,
    parameter int W = sel_width_f(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    input  logic         update,
    output logic [N-1:0] gnt,
    output logic [W-1:0] idx,
    output logic         any,
    output logic [W-1:0] next_ptr
);

    // Scan from ptr upwards modulo N; first hit wins.
    always_comb begin
        int c;
        c   = 0;
        gnt = '0;
        idx = '0;
        any = 1'b0;
        for (int k = 0; k < N; k++) begin
            c = (int'(ptr) + k) % N;
            if (!any && req[c]) begin
                any    = 1'b1;
                gnt[c] = 1'b1;
                idx    = W'(c);
            end
        end
    end

    // Pointer advances past the winner only when the grant is used.
    always_comb begin
        next_ptr = ptr;
        if (update && any) begin
            next_ptr = (int'(idx) == N - 1) ? '0 : W'(int'(idx) + 1);
        end
    end

endmodule

// File: rtl/router_output_allocator.sv
// Switch allocator: per-output round-robin with wormhole locking,
// downstream credit tracking and turn masking. Grants are combinational
// from registered state plus current requests (zero-cycle allocation).
module router_output_allocator
    import router_alloc_pkg::*;
#(
    parameter int NUM_INPUTS        = 5,
    parameter int NUM_OUTPUTS       = 5,
    parameter int FLIT_BUFFER_DEPTH = 4,
    parameter int SEL_WIDTH         = sel_width_f(NUM_INPUTS),
    parameter int PORT_WIDTH        = port_width_f(NUM_OUTPUTS),
    parameter int CREDIT_WIDTH      = credit_width_f(FLIT_BUFFER_DEPTH)
) (
    input  logic                                     clk_noc,
    input  logic                                     rst_noc_sync,
    input  logic [NUM_INPUTS-1:0]                    req_valid,
    input  logic [NUM_INPUTS-1:0][PORT_WIDTH-1:0]    req_route,
    input  logic [NUM_INPUTS-1:0]                    req_is_tail,
    input  logic [NUM_INPUTS-1:0][NUM_OUTPUTS-1:0]   disable_turns,
    input  logic [NUM_OUTPUTS-1:0]                   credit_in,
    output logic [NUM_INPUTS-1:0]                    grant,
    output logic [NUM_OUTPUTS-1:0]                   out_send,
    output logic [NUM_OUTPUTS-1:0][SEL_WIDTH-1:0]    out_sel,
    output logic [NUM_OUTPUTS-1:0]                   out_locked,
    output logic [NUM_OUTPUTS-1:0][CREDIT_WIDTH-1:0] credit_count,
    output logic                                     credit_overflow
);

    localparam logic [CREDIT_WIDTH-1:0] CREDIT_FULL = CREDIT_WIDTH'(FLIT_BUFFER_DEPTH);

    logic                                      rst;
    logic [NUM_OUTPUTS-1:0][NUM_INPUTS-1:0]    elig;     // elig[o][i]: input i wants o, turn allowed
    logic [NUM_OUTPUTS-1:0][NUM_INPUTS-1:0]    gnt_mat;  // per-output one-hot input grant
    logic [NUM_OUTPUTS-1:0]                    ovf_evt;

    assign rst = rst_noc_sync;

    // Eligibility matrix, transposed so each output sees its requester column.
    always_comb begin
        elig = '0;
        for (int o = 0; o < NUM_OUTPUTS; o++) begin
            for (int i = 0; i < NUM_INPUTS; i++) begin
                elig[o][i] = req_valid[i] && (int'(req_route[i]) == o) && !disable_turns[i][o];
            end
        end
    end

    for (genvar o = 0; o < NUM_OUTPUTS; o++) begin : g_out
        alloc_state_e              state_q;
        logic [SEL_WIDTH-1:0]      owner_q;
        logic [SEL_WIDTH-1:0]      ptr_q;
        logic [CREDIT_WIDTH-1:0]   cnt_q;
        logic [NUM_INPUTS-1:0]     arb_req;
        logic [NUM_INPUTS-1:0]     arb_gnt;
        logic [SEL_WIDTH-1:0]      arb_idx;
        logic [SEL_WIDTH-1:0]      nxt_ptr;
        logic                      arb_any;
        logic                      arb_upd;
        logic                      has_credit;
        logic                      send;
        logic                      tail;
        logic [SEL_WIDTH-1:0]      sel;
        logic [NUM_INPUTS-1:0]     gvec;

        assign has_credit = (cnt_q != '0);

        // While locked the arbiter is bypassed, so its pointer stays put.
        assign arb_req = (state_q == IDLE) ? elig[o] : '0;
        assign arb_upd = send && (state_q == IDLE);

        rr_arbiter #(
            .N (NUM_INPUTS),
            .W (SEL_WIDTH)
        ) u_arb (
            .req      (arb_req),
            .ptr      (ptr_q),
            .update   (arb_upd),
            .gnt      (arb_gnt),
            .idx      (arb_idx),
            .any      (arb_any),
            .next_ptr (nxt_ptr)
        );

        // Grant decision: arbiter winner when idle, only the owner when locked.
        always_comb begin
            send = 1'b0;
            sel  = '0;
            gvec = '0;
            if (!rst) begin
                if (state_q == IDLE) begin
                    if (arb_any && has_credit) begin
                        send = 1'b1;
                        sel  = arb_idx;
                        gvec = arb_gnt;
                    end
                end else if (elig[o][owner_q] && has_credit) begin
                    send          = 1'b1;
                    sel           = owner_q;
                    gvec[owner_q] = 1'b1;
                end
            end
        end

        assign tail = req_is_tail[sel];

        // Lock on a granted head/body flit, release on a granted tail.
        always_ff @(posedge clk_noc) begin
            if (rst) begin
                state_q <= IDLE;
                owner_q <= '0;
                ptr_q   <= '0;
            end else begin
                ptr_q <= nxt_ptr;
                if (send) begin
                    if (tail) begin
                        state_q <= IDLE;
                    end else begin
                        state_q <= LOCKED;
                        owner_q <= sel;
                    end
                end
            end
        end

        // Credit counter; a return at full with no send is dropped.
        always_ff @(posedge clk_noc) begin
            if (rst) begin
                cnt_q <= CREDIT_FULL;
            end else begin
                case ({send, credit_in[o]})
                    2'b10:   cnt_q <= cnt_q - 1'b1;
                    2'b01:   if (cnt_q != CREDIT_FULL) cnt_q <= cnt_q + 1'b1;
                    default: cnt_q <= cnt_q;
                endcase
            end
        end

        assign ovf_evt[o]      = !rst && credit_in[o] && !send && (cnt_q == CREDIT_FULL);
        assign out_send[o]     = send;
        assign out_sel[o]      = sel;
        assign gnt_mat[o]      = gvec;
        assign out_locked[o]   = (state_q == LOCKED) && !rst;
        assign credit_count[o] = rst ? CREDIT_FULL : cnt_q;
    end

    // Each input routes to one output, so OR-ing per-output grants never conflicts.
    always_comb begin
        grant = '0;
        for (int o = 0; o < NUM_OUTPUTS; o++) begin
            grant = grant | gnt_mat[o];
        end
    end

    // Sticky overflow flag, cleared only by reset.
    always_ff @(posedge clk_noc) begin
        if (rst) begin
            credit_overflow <= 1'b0;
        end else if (|ovf_evt) begin
            credit_overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_router_output_allocator.sv
// Directed bench for the switch allocator with hand-computed expectations.
module tb_router_output_allocator;

    localparam int NI = 5;
    localparam int NO = 5;
    localparam int SW = 3;
    localparam int PW = 3;
    localparam int CW = 3;

    logic                   clk_noc = 1'b0;
    logic                   rst_noc_sync;
    logic [NI-1:0]          req_valid;
    logic [NI-1:0][PW-1:0]  req_route;
    logic [NI-1:0]          req_is_tail;
    logic [NI-1:0][NO-1:0]  disable_turns;
    logic [NO-1:0]          credit_in;
    logic [NI-1:0]          grant;
    logic [NO-1:0]          out_send;
    logic [NO-1:0][SW-1:0]  out_sel;
    logic [NO-1:0]          out_locked;
    logic [NO-1:0][CW-1:0]  credit_count;
    logic                   credit_overflow;

    logic [NO-1:0][CW-1:0]  full_v;
    int n_vec  = 0;
    int n_miss = 0;

    router_output_allocator dut (
        .clk_noc         (clk_noc),
        .rst_noc_sync    (rst_noc_sync),
        .req_valid       (req_valid),
        .req_route       (req_route),
        .req_is_tail     (req_is_tail),
        .disable_turns   (disable_turns),
        .credit_in       (credit_in),
        .grant           (grant),
        .out_send        (out_send),
        .out_sel         (out_sel),
        .out_locked      (out_locked),
        .credit_count    (credit_count),
        .credit_overflow (credit_overflow)
    );

    always #5 clk_noc = ~clk_noc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_in();
        req_valid   = '0;
        req_route   = '0;
        req_is_tail = '0;
        credit_in   = '0;
    endtask

    task automatic cyc();
        @(posedge clk_noc);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic do_reset();
        rst_noc_sync = 1'b1;
        clear_in();
        cyc();
        cyc();
        rst_noc_sync = 1'b0;
    endtask

    task automatic req(input int i, input int o, input logic tl);
        req_valid[i]   = 1'b1;
        req_route[i]   = PW'(o);
        req_is_tail[i] = tl;
    endtask

    initial begin
        int seq[6];
        full_v        = {NO{3'd4}};
        disable_turns = '0;

        // Reset: outputs forced quiet even with requests and credits applied.
        rst_noc_sync = 1'b1;
        clear_in();
        for (int i = 0; i < NI; i++) req(i, 0, 1'b1);
        credit_in = '1;
        #1;
        settle();
        chk("rst_grant", 32'(grant), 32'h0);
        chk("rst_send", 32'(out_send), 32'h0);
        chk("rst_locked", 32'(out_locked), 32'h0);
        chk("rst_credit", 32'(credit_count), 32'(full_v));
        cyc();
        chk("rst_credit_edge", 32'(credit_count), 32'(full_v));
        chk("rst_ovf", 32'(credit_overflow), 32'h0);
        chk("rst_sel", 32'(out_sel), 32'h0);
        clear_in();
        cyc();
        rst_noc_sync = 1'b0;

        // Fairness: 1,2,3 round-robin on output 0, credits refilled every cycle.
        req(1, 0, 1'b1);
        req(2, 0, 1'b1);
        req(3, 0, 1'b1);
        credit_in[0] = 1'b1;
        seq = '{1, 2, 3, 1, 2, 3};
        for (int k = 0; k < 6; k++) begin
            settle();
            chk("fair_grant", 32'(grant), 32'(1) << seq[k]);
            chk("fair_sel", 32'(out_sel[0]), 32'(seq[k]));
            chk("fair_send", 32'(out_send[0]), 32'h1);
            cyc();
        end
        clear_in();
        settle();
        chk("fair_credit", 32'(credit_count[0]), 32'd4);
        chk("fair_ovf", 32'(credit_overflow), 32'h0);

        // Wormhole lock: input 1 holds output 2 for 3 flits, input 4 waits.
        do_reset();
        req(1, 2, 1'b0);
        settle();
        chk("lock_c0_grant", 32'(grant), 32'b00010);
        chk("lock_c0_locked", 32'(out_locked[2]), 32'h0);
        cyc();
        req(4, 2, 1'b1);
        settle();
        chk("lock_c1_grant", 32'(grant), 32'b00010);
        chk("lock_c1_locked", 32'(out_locked[2]), 32'h1);
        cyc();
        req_is_tail[1] = 1'b1;
        settle();
        chk("lock_c2_grant", 32'(grant), 32'b00010);
        chk("lock_c2_locked", 32'(out_locked[2]), 32'h1);
        cyc();
        req_valid[1] = 1'b0;
        settle();
        chk("lock_c3_grant", 32'(grant), 32'b10000);
        chk("lock_c3_sel", 32'(out_sel[2]), 32'd4);
        chk("lock_c3_locked", 32'(out_locked[2]), 32'h0);
        cyc();
        clear_in();
        settle();
        chk("lock_c4_locked", 32'(out_locked[2]), 32'h0);
        chk("lock_c4_credit", 32'(credit_count[2]), 32'd0);

        // Credit stall: four body flits drain output 3, one credit funds one more.
        do_reset();
        req(0, 3, 1'b0);
        for (int k = 0; k < 4; k++) begin
            settle();
            chk("stall_grant", 32'(grant), 32'b00001);
            cyc();
        end
        settle();
        chk("stall_grant0", 32'(grant), 32'h0);
        chk("stall_send0", 32'(out_send[3]), 32'h0);
        chk("stall_credit0", 32'(credit_count[3]), 32'd0);
        chk("stall_locked", 32'(out_locked[3]), 32'h1);
        cyc();
        credit_in[3] = 1'b1;
        settle();
        chk("stall_same_cycle", 32'(grant), 32'h0);
        cyc();
        credit_in[3] = 1'b0;
        settle();
        chk("stall_refund_cnt", 32'(credit_count[3]), 32'd1);
        chk("stall_refund_grant", 32'(grant), 32'b00001);
        cyc();
        settle();
        chk("stall_again_grant", 32'(grant), 32'h0);
        chk("stall_again_cnt", 32'(credit_count[3]), 32'd0);

        // Send and credit together leave the count alone; return at full overflows.
        do_reset();
        req(2, 1, 1'b1);
        settle();
        chk("sc_grant0", 32'(grant), 32'b00100);
        cyc();
        credit_in[1] = 1'b1;
        settle();
        chk("sc_cnt_before", 32'(credit_count[1]), 32'd3);
        chk("sc_grant1", 32'(grant), 32'b00100);
        cyc();
        req_valid = '0;
        settle();
        chk("sc_cnt_same", 32'(credit_count[1]), 32'd3);
        cyc();
        settle();
        chk("sc_cnt_full", 32'(credit_count[1]), 32'd4);
        chk("sc_ovf_pre", 32'(credit_overflow), 32'h0);
        cyc();
        credit_in = '0;
        settle();
        chk("sc_ovf_set", 32'(credit_overflow), 32'h1);
        chk("sc_cnt_cap", 32'(credit_count[1]), 32'd4);
        cyc();
        settle();
        chk("sc_ovf_sticky", 32'(credit_overflow), 32'h1);

        // Disabled turn: input 2 -> output 2 is never granted.
        do_reset();
        disable_turns[2][2] = 1'b1;
        req(2, 2, 1'b1);
        req(3, 2, 1'b1);
        credit_in[2] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            settle();
            chk("turn_grant", 32'(grant), 32'b01000);
            cyc();
        end
        req_valid[3] = 1'b0;
        for (int k = 0; k < 2; k++) begin
            settle();
            chk("turn_blocked", 32'(grant), 32'h0);
            chk("turn_nosend", 32'(out_send[2]), 32'h0);
            cyc();
        end
        clear_in();
        disable_turns = '0;

        // Reset while output 0 is locked with one credit left.
        do_reset();
        req(1, 0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            settle();
            chk("mid_grant", 32'(grant), 32'b00010);
            cyc();
        end
        settle();
        chk("mid_locked", 32'(out_locked[0]), 32'h1);
        chk("mid_cnt", 32'(credit_count[0]), 32'd1);
        rst_noc_sync = 1'b1;
        credit_in[0] = 1'b1;
        #1;
        chk("mid_rst_grant", 32'(grant), 32'h0);
        cyc();
        settle();
        chk("mid_rst_locked", 32'(out_locked), 32'h0);
        chk("mid_rst_credit", 32'(credit_count), 32'(full_v));
        chk("mid_rst_grant2", 32'(grant), 32'h0);
        cyc();
        clear_in();
        rst_noc_sync = 1'b0;
        req(3, 0, 1'b0);
        settle();
        chk("mid_new_grant", 32'(grant), 32'b01000);
        cyc();
        settle();
        chk("mid_new_locked", 32'(out_locked[0]), 32'h1);
        chk("mid_new_cnt", 32'(credit_count[0]), 32'd3);
        clear_in();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
